multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multi-cycle RV32I datapath; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction class and waits on a variable-latency memory (mem_ready).
//  Watchdogs each memory access and counts retired instructions.
//  Sits between the instruction register/PC and the shared memory port, ALU and register file.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready per access; 0 disables the watchdog
//  CNT_W        32  width of the retired-instruction counter
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-high reset
//  Opcode     in   7      instr[6:0], valid from IR after FETCH completes
//  mem_ready  in   1      memory completes current read/write this cycle
//  br_taken   in   1      ALU compare result, valid in BRANCH state
//  PCWrite    out  1      load PC (PC+4 in FETCH, target in BRANCH/JUMP)
//  IRWrite    out  1      load instruction register
//  IorD       out  1      0: memory address = PC; 1: address = ALU result
//  MemRead    out  1      memory read request, held until mem_ready
//  MemWrite   out  1      memory write request, held until mem_ready
//  RegWrite   out  1      register file write enable
//  ALUSrc     out  1      0: rs2; 1: immediate
//  MemtoReg   out  2      00 ALU, 01 memory data, 10 PC+4
//  ALUOp      out  2      00 add (LW/SW/JALR), 01 branch, 10 R/I-type, 11 LUI/JAL
//  Branch     out  1      BRANCH state active
//  jals       out  1      JUMP state active
//  mem_err    out  1      sticky: watchdog expired
//  illegal    out  1      sticky: illegal opcode trapped (see CONFIGURATION)
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Moore outputs: decoded from state and op_q (opcode latched in DECODE). Unlisted outputs are 0 in each state.
//  - Reset: state = RST, op_q = 0, instret = 0, mem_err = 0, illegal = 0, timer = 0; every output 0.
//  - Reset asserted mid-operation aborts immediately; MemWrite/MemRead drop asynchronously.
//  - RST  -> FETCH on the first clock edge after reset is released.
//  - FETCH: MemRead=1, IorD=0. Holds until mem_ready. In that cycle IRWrite=1 and PCWrite=1, then -> DECODE.
//  - DECODE (1 cycle) latches Opcode, then dispatches:
//    - LW/SW -> ADDR
//    - R (0110011), I (0010011), LUI (0110111) -> EXEC
//    - BR (1100011) -> BRANCH
//    - JAL (1101111), JALR (1100111) -> JUMP
//    - other -> see CONFIGURATION
//  - ADDR: ALUSrc=1, ALUOp=00; LW -> MEM_RD, SW -> MEM_WR.
//  - MEM_RD: MemRead=1, IorD=1, ALUSrc=1; on mem_ready -> WB_MEM.
//  - WB_MEM: RegWrite=1, MemtoReg=01 -> FETCH (retire).
//  - MEM_WR: MemWrite=1, IorD=1, ALUSrc=1; on mem_ready -> FETCH (retire).
//  - EXEC: ALUSrc=1 for I/LUI; ALUOp=10 for R/I, 11 for LUI; -> WB_ALU.
//  - WB_ALU: RegWrite=1, MemtoReg=00, same ALUSrc/ALUOp as EXEC -> FETCH (retire).
//  - BRANCH: ALUOp=01, Branch=1, PCWrite=br_taken -> FETCH (retire).
//  - JUMP: jals=1, ALUSrc=1, RegWrite=1, MemtoReg=10, PCWrite=1; ALUOp=11 for JAL, 00 for JALR -> FETCH (retire).
//  - Latency with mem_ready already high on entry:
//    - LW 5 cycles; SW, R, I, LUI 4 cycles; BR, JAL, JALR 3 cycles.
//    - Each extra wait cycle adds 1.
//  - Retire: instret += 1 on the edge leaving a retiring state; wraps 2^CNT_W-1 -> 0.
//  - Watchdog: timer clears on entry to FETCH/MEM_RD/MEM_WR and counts while mem_ready=0.
//    - On the MEM_TIMEOUT-th consecutive wait cycle -> ERR.
//    - mem_ready in that same cycle wins: normal transition, no error.
//  - ERR: mem_err=1, all other outputs 0, no exit except reset.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - an unknown opcode in DECODE -> TRAP; illegal=1 sticky, all other outputs 0.
//    - TRAP does not retire; exit only by reset.
//  ILLEGAL_TRAP_EN undefined:
//    - an unknown opcode is a NOP: DECODE -> FETCH, retires (instret += 1).
//    - illegal is tied to 0; no TRAP state exists.
// STRUCTURE
//  - ctrl_pkg holds:
//    - opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, U_TYPE, JAL, JALR)
//    - state_t enum (RST, FETCH, DECODE, ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC, WB_ALU, BRANCH, JUMP, ERR, TRAP)
//    - ALUOp and MemtoReg encodings
//  - Sub-module mem_watchdog #(MEM_TIMEOUT): inputs clk, reset, clear, waiting; output expired.
// TESTING
//  1. Reset then ADDI (0010011), mem_ready=1 always -> FETCH,DECODE,EXEC,WB_ALU; RegWrite=1 only in WB_ALU; instret=1 after 4 cycles.
//  2. LW with mem_ready low for 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles; WB_MEM MemtoReg=01; total 8 cycles.
//  3. BEQ with br_taken=0 -> PCWrite=0 in BRANCH; br_taken=1 -> PCWrite=1. JAL -> jals=1, MemtoReg=10, PCWrite=1.
//  4. MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERR after 4 wait cycles, mem_err=1, MemRead=0; 5th-cycle mem_ready ignored.
//  5. Opcode 7'h7F: with ILLEGAL_TRAP_EN -> illegal=1, FSM halts, instret unchanged; without -> back to FETCH, instret+1.
//  6. Reset asserted during MEM_WR -> MemWrite=0 without a clock edge; instret=0.
//     Also: instret preloaded near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and control encodings for the multi-cycle controller.
// ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_UJ  = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [3:0] {
    RST,
    FETCH,
    DECODE,
    ADDR,
    MEM_RD,
    MEM_WR,
    WB_MEM,
    EXEC,
    WB_ALU,
    BRANCH,
    JUMP,
`ifdef ILLEGAL_TRAP_EN
    ERR,
    TRAP
`else
    ERR
`endif
  } state_t;

  // ALU op for the EXEC/WB_ALU pair: LUI passes the immediate through
  function automatic logic [1:0] exec_aluop(input logic [6:0] op);
    return (op == U_TYPE) ? ALUOP_UJ : ALUOP_RI;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive memory wait cycles and flags the MEM_TIMEOUT-th one.
// MEM_TIMEOUT = 0 disables the watchdog.
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned TW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LIM =
    TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign expired = (MEM_TIMEOUT != 0)
                && waiting
                && (timer_q == LIM);

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (waiting && !expired) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory watchdog and retire counter.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             jals,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_wait, wd_clear, wd_wait, wd_exp;
  logic             retire;
`ifdef ILLEGAL_TRAP_EN
  logic             ill_q, ill_d;
`endif

  // Timer restarts whenever we are outside a wait state or an access completes
  assign mem_wait = (state_q == FETCH)
                 || (state_q == MEM_RD)
                 || (state_q == MEM_WR);
  assign wd_wait  = mem_wait && !mem_ready;
  assign wd_clear = !mem_wait || mem_ready;

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .waiting(wd_wait),
    .expired(wd_exp)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    unique case (state_q)
      RST:    state_d = FETCH;
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else if (wd_exp) state_d = ERR;
      end
      DECODE: begin
        op_d = Opcode;
        unique case (1'b1)
          (Opcode == LW) || (Opcode == SW):
            state_d = ADDR;
          (Opcode == R_TYPE) || (Opcode == I_TYPE)
            || (Opcode == U_TYPE):
            state_d = EXEC;
          (Opcode == BR):
            state_d = BRANCH;
          (Opcode == JAL) || (Opcode == JALR):
            state_d = JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = TRAP;
            ill_d   = 1'b1;
`else
            state_d = FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      ADDR:   state_d = (op_q == SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready) state_d = WB_MEM;
        else if (wd_exp) state_d = ERR;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (wd_exp) begin
          state_d = ERR;
        end
      end
      EXEC:   state_d = WB_ALU;
      WB_MEM, WB_ALU, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ERR:    state_d = ERR;
`ifdef ILLEGAL_TRAP_EN
      TRAP:   state_d = TRAP;
`endif
      default: state_d = RST;
    endcase
    err_d = err_q | wd_exp;
    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = MTR_ALU;
    ALUOp    = ALUOP_ADD;
    Branch   = 1'b0;
    jals     = 1'b0;
    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ADDR: ALUSrc = 1'b1;
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        ALUSrc  = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        ALUSrc   = 1'b1;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_MEM;
      end
      EXEC: begin
        ALUSrc = (op_q != R_TYPE);
        ALUOp  = exec_aluop(op_q);
      end
      WB_ALU: begin
        ALUSrc   = (op_q != R_TYPE);
        ALUOp    = exec_aluop(op_q);
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUOp   = ALUOP_BR;
        Branch  = 1'b1;
        PCWrite = br_taken;
      end
      JUMP: begin
        jals     = 1'b1;
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = MTR_PC4;
        PCWrite  = 1'b1;
        ALUOp    = (op_q == JAL) ? ALUOP_UJ : ALUOP_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  assign mem_err = err_q;
  assign instret = cnt_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction expected signatures are queued by the
// driver and matched by a monitor on every retirement.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [7:0] cyc;
    logic [7:0] mrd;
    logic [7:0] mwr;
    logic [7:0] iord;
    logic [7:0] rw;
    logic [7:0] pcw;
    logic [7:0] irw;
    logic [7:0] brn;
    logic [7:0] jmp;
    logic [7:0] asrc;
    logic [1:0] mtr;
    logic [1:0] aop;
    logic [3:0] cnt;
  } rec_t;

  logic          clk, reset;
  logic [6:0]    Opcode;
  logic          mem_ready, br_taken;
  logic          PCWrite, IRWrite, IorD, MemRead, MemWrite;
  logic          RegWrite, ALUSrc, Branch, jals, mem_err, illegal;
  logic [1:0]    MemtoReg, ALUOp;
  logic [CW-1:0] instret;

  multicycle_controller #(
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .mem_ready(mem_ready), .br_taken(br_taken),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .ALUOp(ALUOp),
    .Branch(Branch), .jals(jals), .mem_err(mem_err),
    .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mcnt    = 0;
  rec_t expq[$];
  logic [6:0] opq[$];

  wire [12:0] outs = {PCWrite, IRWrite, IorD, MemRead, MemWrite,
                      RegWrite, ALUSrc, MemtoReg, ALUOp, Branch, jals};

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_U, OP_JAL, OP_JALR};
  endfunction

  // Expected per-instruction signature from the class timing rules
  function automatic rec_t model(input logic [6:0] op, input int wf,
                                 input int wm, input logic bt, input int cnt);
    rec_t r;
    r     = '0;
    r.cyc = 8'(2 + wf);
    r.mrd = 8'(wf + 1);
    r.pcw = 8'd1;
    r.irw = 8'd1;
    r.cnt = 4'(cnt);
    case (op)
      OP_LW: begin
        r.cyc  = r.cyc + 8'(3 + wm);
        r.mrd  = r.mrd + 8'(wm + 1);
        r.iord = 8'(wm + 1);
        r.asrc = 8'(wm + 2);
        r.rw   = 8'd1;
        r.mtr  = 2'b01;
      end
      OP_SW: begin
        r.cyc  = r.cyc + 8'(2 + wm);
        r.mwr  = 8'(wm + 1);
        r.iord = 8'(wm + 1);
        r.asrc = 8'(wm + 2);
      end
      OP_R, OP_I, OP_U: begin
        r.cyc  = r.cyc + 8'd2;
        r.rw   = 8'd1;
        r.asrc = (op == OP_R) ? 8'd0 : 8'd2;
        r.aop  = (op == OP_U) ? 2'b11 : 2'b10;
      end
      OP_BR: begin
        r.cyc = r.cyc + 8'd1;
        r.brn = 8'd1;
        r.aop = 2'b01;
        r.pcw = bt ? 8'd2 : 8'd1;
      end
      OP_JAL, OP_JALR: begin
        r.cyc  = r.cyc + 8'd1;
        r.jmp  = 8'd1;
        r.asrc = 8'd1;
        r.rw   = 8'd1;
        r.mtr  = 2'b10;
        r.pcw  = 8'd2;
        r.aop  = (op == OP_JAL) ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic cyc(input logic mr, input logic bt, input logic [6:0] op);
    mem_ready = mr;
    br_taken  = bt;
    Opcode    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input int wf, input int wm,
                       input logic bt);
    mcnt = (mcnt + 1) % (1 << CW);
    expq.push_back(model(op, wf, wm, bt, mcnt));
    opq.push_back(op);
    repeat (wf) cyc(1'b0, rb(), rop());
    cyc(1'b1, rb(), rop());
    cyc(rb(), rb(), op);
    case (op)
      OP_LW: begin
        cyc(rb(), rb(), rop());
        repeat (wm) cyc(1'b0, rb(), rop());
        cyc(1'b1, rb(), rop());
        cyc(rb(), rb(), rop());
      end
      OP_SW: begin
        cyc(rb(), rb(), rop());
        repeat (wm) cyc(1'b0, rb(), rop());
        cyc(1'b1, rb(), rop());
      end
      OP_R, OP_I, OP_U: begin
        cyc(rb(), rb(), rop());
        cyc(rb(), rb(), rop());
      end
      OP_BR: cyc(rb(), bt, rop());
      OP_JAL, OP_JALR: cyc(rb(), rb(), rop());
      default: ;
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 3 && expq.size() != 0; i++)
      cyc(1'b0, rb(), rop());
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, required 0", expq.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mcnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(rb(), rb(), rop());
  endtask

  // Monitor: accumulate outputs per instruction, compare on retirement
  initial begin : monitor
    rec_t          acc, e;
    logic          armed;
    logic [CW-1:0] prev;
    logic [6:0]    o;
    acc   = '0;
    armed = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1'b0;
        acc   = '0;
        prev  = instret;
      end else begin
        if (armed && instret != prev) begin
          n_tests++;
          acc.cnt = instret;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL retire: unexpected retirement, instret %0d", instret);
          end else begin
            e = expq.pop_front();
            o = opq.pop_front();
            if (acc !== e) begin
              n_fail++;
              $display("FAIL retire op=%b: got %h required %h", o, acc, e);
            end
          end
          acc = '0;
        end
        if (!armed && MemRead && !IorD) armed = 1'b1;
        if (armed) begin
          acc.cyc  = acc.cyc + 8'd1;
          acc.mrd  = acc.mrd + 8'(MemRead);
          acc.mwr  = acc.mwr + 8'(MemWrite);
          acc.iord = acc.iord + 8'(IorD);
          acc.rw   = acc.rw + 8'(RegWrite);
          acc.pcw  = acc.pcw + 8'(PCWrite);
          acc.irw  = acc.irw + 8'(IRWrite);
          acc.brn  = acc.brn + 8'(Branch);
          acc.jmp  = acc.jmp + 8'(jals);
          acc.asrc = acc.asrc + 8'(ALUSrc);
          acc.aop  = acc.aop | ALUOp;
          if (RegWrite) acc.mtr = MemtoReg;
        end
        prev = instret;
      end
    end
  end

  initial begin : driver
    logic [6:0] op;
    reset     = 1'b1;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    Opcode    = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs), 0);
    chk("reset_instret", 32'(instret), 0);
    chk("reset_flags", {mem_err, illegal}, 0);
    reset = 1'b0;
    cyc(rb(), rb(), rop());

    issue(OP_I, 0, 0, 1'b0);
    issue(OP_LW, 0, 3, 1'b0);
    issue(OP_BR, 0, 0, 1'b0);
    issue(OP_BR, 1, 0, 1'b1);
    issue(OP_JAL, 0, 0, 1'b0);
    issue(OP_JALR, 2, 0, 1'b0);
    issue(OP_SW, 3, 3, 1'b0);
    issue(OP_U, 0, 1, 1'b0);
    issue(OP_R, 1, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
    issue(7'h7F, 0, 0, 1'b0);
`endif
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BR;
        5: op = OP_U;
        6: op = OP_JAL;
        7: op = OP_JALR;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          op = OP_LW;
`else
          op = rop();
          while (known(op)) op = rop();
`endif
        end
      endcase
      issue(op, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rb());
    end
    drain();

`ifdef ILLEGAL_TRAP_EN
    cyc(1'b1, rb(), rop());
    cyc(rb(), rb(), 7'h7F);
    chk("trap_illegal", 32'(illegal), 1);
    repeat (3) cyc(1'b1, rb(), rop());
    chk("trap_halt", 32'(outs), 0);
    chk("trap_instret", 32'(instret), 32'(mcnt));
    chk("trap_sticky", 32'(illegal), 1);
`else
    chk("illegal_tied", 32'(illegal), 0);
`endif

    do_reset();
    issue(OP_I, 0, 0, 1'b0);
    drain();
    cyc(1'b1, rb(), rop());
    cyc(rb(), rb(), OP_SW);
    cyc(rb(), rb(), rop());
    mem_ready = 1'b0;
    #1;
    chk("memwr_active", 32'(MemWrite), 1);
    chk("memwr_instret", 32'(instret), 1);
    reset = 1'b1;
    mcnt  = 0;
    #1;
    chk("async_memwr_drop", 32'(MemWrite), 0);
    chk("async_outputs", 32'(outs), 0);
    chk("async_instret", 32'(instret), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(rb(), rb(), rop());

    repeat (TO - 1) cyc(1'b0, rb(), rop());
    chk("wd_before", {mem_err, MemRead}, 2'b01);
    cyc(1'b0, rb(), rop());
    chk("wd_expired", {mem_err, MemRead}, 2'b10);
    cyc(1'b1, rb(), rop());
    chk("wd_late_ready", {mem_err, outs}, {1'b1, 13'b0});
    cyc(1'b1, rb(), rop());
    chk("wd_stuck", {mem_err, outs, instret}, {1'b1, 13'b0, 4'b0});

    chk("queue_empty", 32'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
